cam_subarray_exp: RTL and testbench
===================================

# cam_subarray_exp

Bit-serial associative-processing CAM subarray: a 40-row × 32-column storage array organised as 16 two-bit entries per row, with masked writes, per-entry compare, and a 16-bit tag register that can accumulate search results. It sits under the CAM array controller, which sequences operation codes each cycle, and exports per-entry match tags to the reduction/priority logic.

## Interface
No parameters (geometry fixed: 40 rows, 32 columns, 16 entries/row).
- CLK  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- chip_enable  input  1  1 = execute operation_mode this cycle; 0 = hold all state
- operation_mode  input  3  operation code (see Operation)
- addr_select  input  1  row/bit-plane select (per mode)
- cmp_addr  input  10  two 5-bit row addresses: [9:5] and [4:0] (rows 0–31)
- ppg_addr  input  4  propagate-row address; [2:0] selects row 32+ppg_addr[2:0]; [3] reserved, ignored
- data_in  input  16  direct-write bit-plane data, bit k → entry k
- update_signal  input  1  write enable for masked-write modes
- tag_in  input  16  per-entry write mask for mode 001
- cmp_data  input  2  compare key for mode 010
- ppg_data  input  2  write/compare value for modes 001, 011, 100
- acc_en  input  1  1 = search result ORed into tag_out; 0 = overwrite
- write_done  input  1  synchronous clear of tag_out
- tag_out  output  16  registered tag/match vector, bit k ↔ entry k

## Operation
- Storage: internal array `mem[0:1279]`, bit (row r, column c) at index r*32+c; entry k of a row = {col 2k+1 (msb), col 2k (lsb)}. Array is not reset; benches may preload via hierarchy.
- Priority per rising edge: chip_enable=0 → nothing changes; else write_done=1 → tag_out←0, no array access; else execute operation_mode.
- 000 DIRECT_WRITE: row R=cmp_addr[9:5]; addr_select=1 → col 2k+1 ← data_in[k]; addr_select=0 → col 2k ← data_in[k]; other plane unchanged. tag_out unchanged.
- 001 MASKED_WRITE: R = addr_select ? cmp_addr[9:5] : cmp_addr[4:0]; if update_signal=1, entry k ← ppg_data for every k with tag_in[k]=1; unmasked entries unchanged; update_signal=0 → no write.
- 010 SEARCH: R=cmp_addr[4:0]; match[k]=(entry k == cmp_data); tag_out ← acc_en ? (tag_out | match) : match.
- 011 PPG_SEARCH: R=32+ppg_addr[2:0]; match[k]=(entry k == ppg_data); same accumulate rule as 010.
- 100 TAG_WRITE: R=32+ppg_addr[2:0]; if update_signal=1, entry k ← ppg_data where tag_out[k]=1.
- 101 READ: R=cmp_addr[4:0]; tag_out[k] ← addr_select ? col 2k+1 : col 2k.
- 110 CLEAR: tag_out ← 0.  111 NOP.
- Searches/reads use array contents before the edge; only one array access per cycle, so no read/write hazard.

## Timing
- rst=0: tag_out=0 immediately (async), held until rst=1; array contents retained. First operation executes at first rising edge with rst=1.
- All ops single-cycle: writes visible in mem, and tag_out updated, directly after the executing edge; tag_out is purely registered (no combinational path from inputs).
- Back-to-back searches with acc_en=1 accumulate across any number of cycles; acc_en=0 restarts accumulation.
- Reset mid-accumulation clears tag_out; array writes in progress at that edge do not occur.

## Test plan
- Zero array, rst low 20 ns → tag_out=0x0000; release, mode 000, addr_select=1, cmp_addr=0x020, data_in=0xFFFF → row 1 = 0xAAAAAAAA (cols 31..0), row 0 untouched.
- Mode 001, addr_select=0, cmp_addr=0x020, update_signal=1, tag_in=0xAAAA, ppg_data=2'b10 → row 0 = 0x88888888; repeat with update_signal=0, ppg_data=11 → row 0 unchanged.
- Then mode 010, acc_en=1, cmp_data=01 → tag_out=0x0000; next cycle cmp_data=00 → 0x5555; next cmp_data=10 → 0xFFFF; acc_en=0, cmp_data=01 → 0x0000.
- tag_out=0x5555, ppg_addr=4'h3, mode 100, ppg_data=11, update_signal=1 → row 35 even entries=11; mode 011, ppg_data=11, acc_en=0 → tag_out=0x5555.
- Mode 101 row 1, addr_select=1 → 0xFFFF; addr_select=0 → 0x0000.
- chip_enable=0 with any mode → no mem/tag change; write_done=1 → tag_out=0 next edge; rst pulse mid-search → tag_out=0 asynchronously.

Source files
------------

// File: rtl/cam_subarray_exp.sv
// Bit-serial associative-processing CAM subarray.
// 40 rows x 32 columns, 16 two-bit entries per row (entry k = {col 2k+1, col 2k}).
// Rows 0-31 are reached through cmp_addr, rows 32-39 through ppg_addr.
// One array row is read and at most one row is written per cycle.
// tag_out is a registered per-entry match/tag vector.
module cam_subarray_exp (
  input  logic        CLK,
  input  logic        rst,
  input  logic        chip_enable,
  input  logic [2:0]  operation_mode,
  input  logic        addr_select,
  input  logic [9:0]  cmp_addr,
  input  logic [3:0]  ppg_addr,
  input  logic [15:0] data_in,
  input  logic        update_signal,
  input  logic [15:0] tag_in,
  input  logic [1:0]  cmp_data,
  input  logic [1:0]  ppg_data,
  input  logic        acc_en,
  input  logic        write_done,
  output logic [15:0] tag_out
);

  localparam logic [2:0] OP_DIRECT_WRITE = 3'b000;
  localparam logic [2:0] OP_MASKED_WRITE = 3'b001;
  localparam logic [2:0] OP_SEARCH       = 3'b010;
  localparam logic [2:0] OP_PPG_SEARCH   = 3'b011;
  localparam logic [2:0] OP_TAG_WRITE    = 3'b100;
  localparam logic [2:0] OP_READ         = 3'b101;
  localparam logic [2:0] OP_CLEAR        = 3'b110;

  // Storage is deliberately left without reset; contents survive rst.
  logic        mem [0:1279];

  logic [5:0]  row_s;
  logic [31:0] row_rd_s;
  logic [31:0] row_wr_s;
  logic        wr_en_s;
  logic [15:0] match_s;
  logic [15:0] tag_nxt_s;
  logic [15:0] tag_r;

  // Per-entry equality of a row against a two-bit key.
  function automatic logic [15:0] entry_match(input logic [31:0] row, input logic [1:0] key);
    logic [15:0] m;
    m = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      if (row[2*k +: 2] == key) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

  // Replace every entry selected by mask with val, leaving the rest intact.
  function automatic logic [31:0] masked_fill(input logic [31:0] row, input logic [15:0] mask,
                                              input logic [1:0] val);
    logic [31:0] r;
    r = row;
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) begin
        r[2*k +: 2] = val;
      end else begin
        r[2*k +: 2] = row[2*k +: 2];
      end
    end
    return r;
  endfunction

  // Row address decode for the operation in flight.
  always_comb begin
    row_s = 6'd0;
    case (operation_mode)
      OP_DIRECT_WRITE: row_s = {1'b0, cmp_addr[9:5]};
      OP_MASKED_WRITE: row_s = addr_select ? {1'b0, cmp_addr[9:5]} : {1'b0, cmp_addr[4:0]};
      OP_SEARCH:       row_s = {1'b0, cmp_addr[4:0]};
      OP_READ:         row_s = {1'b0, cmp_addr[4:0]};
      OP_PPG_SEARCH:   row_s = {3'b100, ppg_addr[2:0]};
      OP_TAG_WRITE:    row_s = {3'b100, ppg_addr[2:0]};
      default:         row_s = 6'd0;
    endcase
  end

  // Gather the addressed row into a word (pre-edge contents).
  always_comb begin
    row_rd_s = 32'h0000_0000;
    for (int c = 0; c < 32; c++) begin
      row_rd_s[c] = mem[{row_s, 5'(c)}];
    end
  end

  // Operation decode: write-back row, write enable and next tag value.
  always_comb begin
    wr_en_s   = 1'b0;
    row_wr_s  = row_rd_s;
    match_s   = 16'h0000;
    tag_nxt_s = tag_r;
    if (!chip_enable) begin
      tag_nxt_s = tag_r;
    end else if (write_done) begin
      tag_nxt_s = 16'h0000;
    end else begin
      case (operation_mode)
        OP_DIRECT_WRITE: begin
          wr_en_s = 1'b1;
          for (int k = 0; k < 16; k++) begin
            if (addr_select) begin
              row_wr_s[2*k+1] = data_in[k];
            end else begin
              row_wr_s[2*k] = data_in[k];
            end
          end
        end
        OP_MASKED_WRITE: begin
          wr_en_s  = update_signal;
          row_wr_s = masked_fill(row_rd_s, tag_in, ppg_data);
        end
        OP_SEARCH: begin
          match_s   = entry_match(row_rd_s, cmp_data);
          tag_nxt_s = acc_en ? (tag_r | match_s) : match_s;
        end
        OP_PPG_SEARCH: begin
          match_s   = entry_match(row_rd_s, ppg_data);
          tag_nxt_s = acc_en ? (tag_r | match_s) : match_s;
        end
        OP_TAG_WRITE: begin
          wr_en_s  = update_signal;
          row_wr_s = masked_fill(row_rd_s, tag_r, ppg_data);
        end
        OP_READ: begin
          for (int k = 0; k < 16; k++) begin
            tag_nxt_s[k] = addr_select ? row_rd_s[2*k+1] : row_rd_s[2*k];
          end
        end
        OP_CLEAR: tag_nxt_s = 16'h0000;
        default:  tag_nxt_s = tag_r;
      endcase
    end
  end

  // Array write port; an edge seen while rst is low performs no write.
  always_ff @(posedge CLK) begin
    if (rst && wr_en_s) begin
      for (int c = 0; c < 32; c++) begin
        mem[{row_s, 5'(c)}] <= row_wr_s[c];
      end
    end
  end

  // Tag register with asynchronous clear.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      tag_r <= 16'h0000;
    end else begin
      tag_r <= tag_nxt_s;
    end
  end

  assign tag_out = tag_r;

endmodule

// File: tb/tb_cam_subarray_exp.sv
// Self-checking bench for cam_subarray_exp: directed scenarios plus a
// randomized run against a row-vector reference model.
module tb_cam_subarray_exp;

  logic        CLK = 1'b0;
  logic        rst;
  logic        chip_enable;
  logic [2:0]  operation_mode;
  logic        addr_select;
  logic [9:0]  cmp_addr;
  logic [3:0]  ppg_addr;
  logic [15:0] data_in;
  logic        update_signal;
  logic [15:0] tag_in;
  logic [1:0]  cmp_data;
  logic [1:0]  ppg_data;
  logic        acc_en;
  logic        write_done;
  logic [15:0] tag_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [0:39];
  logic [15:0] m_tag;

  cam_subarray_exp dut (
    .CLK(CLK), .rst(rst), .chip_enable(chip_enable), .operation_mode(operation_mode),
    .addr_select(addr_select), .cmp_addr(cmp_addr), .ppg_addr(ppg_addr),
    .data_in(data_in), .update_signal(update_signal), .tag_in(tag_in),
    .cmp_data(cmp_data), .ppg_data(ppg_data), .acc_en(acc_en),
    .write_done(write_done), .tag_out(tag_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] dut_row(input int r);
    logic [31:0] v;
    for (int c = 0; c < 32; c++) v[c] = dut.mem[r*32 + c];
    return v;
  endfunction

  // Reference behaviour of one enabled clock edge, from the operation rules.
  function automatic void model_edge();
    int r;
    logic [15:0] m;
    if (chip_enable) begin
      if (write_done) m_tag = 16'h0000;
      else begin
        case (operation_mode)
          3'd0: begin
            r = int'(cmp_addr[9:5]);
            for (int k = 0; k < 16; k++) ref_mem[r][2*k + (addr_select ? 1 : 0)] = data_in[k];
          end
          3'd1: begin
            r = addr_select ? int'(cmp_addr[9:5]) : int'(cmp_addr[4:0]);
            if (update_signal)
              for (int k = 0; k < 16; k++) if (tag_in[k]) ref_mem[r][2*k +: 2] = ppg_data;
          end
          3'd2, 3'd3: begin
            if (operation_mode == 3'd2) r = int'(cmp_addr[4:0]);
            else r = 32 + int'(ppg_addr[2:0]);
            for (int k = 0; k < 16; k++)
              m[k] = (ref_mem[r][2*k +: 2] == ((operation_mode == 3'd2) ? cmp_data : ppg_data));
            m_tag = acc_en ? (m_tag | m) : m;
          end
          3'd4: begin
            r = 32 + int'(ppg_addr[2:0]);
            if (update_signal)
              for (int k = 0; k < 16; k++) if (m_tag[k]) ref_mem[r][2*k +: 2] = ppg_data;
          end
          3'd5: begin
            r = int'(cmp_addr[4:0]);
            for (int k = 0; k < 16; k++) m_tag[k] = ref_mem[r][2*k + (addr_select ? 1 : 0)];
          end
          3'd6: m_tag = 16'h0000;
          default: ;
        endcase
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; chip_enable = 1'b0; operation_mode = 3'd7; addr_select = 1'b0;
    cmp_addr = 10'd0; ppg_addr = 4'd0; data_in = 16'h0; update_signal = 1'b0;
    tag_in = 16'h0; cmp_data = 2'd0; ppg_data = 2'd0; acc_en = 1'b0; write_done = 1'b0;
    for (int r = 0; r < 40; r++) ref_mem[r] = 32'h0;
    m_tag = 16'h0;
    #20;
    n_cmp++;
    if (tag_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_tag: got %h want 0000", tag_out);
    end
    @(posedge CLK); #1;
    rst = 1'b1;
  endtask

  task automatic init_array();
    chip_enable = 1'b1;
    data_in = 16'h0000;
    for (int r = 0; r < 32; r++) begin
      operation_mode = 3'd0; cmp_addr = {5'(r), 5'd0};
      addr_select = 1'b0; tick();
      addr_select = 1'b1; tick();
    end
    operation_mode = 3'd2; cmp_addr = 10'd0; cmp_data = 2'b00; acc_en = 1'b0; tick();
    n_cmp++;
    if (tag_out !== 16'hFFFF) begin
      n_err++; $display("FAIL init_search: got %h want ffff", tag_out);
    end
    operation_mode = 3'd4; update_signal = 1'b1; ppg_data = 2'b00;
    for (int p = 0; p < 8; p++) begin
      ppg_addr = 4'(p); tick();
    end
    update_signal = 1'b0;
    operation_mode = 3'd6; tick();
  endtask

  task automatic test_direct_write();
    operation_mode = 3'd0; addr_select = 1'b1; cmp_addr = 10'h020; data_in = 16'hFFFF; tick();
    n_cmp++;
    if (dut_row(1) !== 32'hAAAAAAAA) begin
      n_err++; $display("FAIL dw_row1: got %h want aaaaaaaa", dut_row(1));
    end
    n_cmp++;
    if (dut_row(0) !== 32'h00000000) begin
      n_err++; $display("FAIL dw_row0: got %h want 00000000", dut_row(0));
    end
    n_cmp++;
    if (tag_out !== 16'h0000) begin
      n_err++; $display("FAIL dw_tag: got %h want 0000", tag_out);
    end
  endtask

  task automatic test_masked_write();
    operation_mode = 3'd1; addr_select = 1'b0; cmp_addr = 10'h020; update_signal = 1'b1;
    tag_in = 16'hAAAA; ppg_data = 2'b10; tick();
    n_cmp++;
    if (dut_row(0) !== 32'h88888888) begin
      n_err++; $display("FAIL mw_row0: got %h want 88888888", dut_row(0));
    end
    update_signal = 1'b0; ppg_data = 2'b11; tick();
    n_cmp++;
    if (dut_row(0) !== 32'h88888888) begin
      n_err++; $display("FAIL mw_noupd: got %h want 88888888", dut_row(0));
    end
  endtask

  task automatic test_search_acc();
    logic [1:0]  keys [4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    logic        accs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exps [4] = '{16'h0000, 16'h5555, 16'hFFFF, 16'h0000};
    operation_mode = 3'd2; cmp_addr = 10'h020;
    for (int i = 0; i < 4; i++) begin
      cmp_data = keys[i]; acc_en = accs[i]; tick();
      n_cmp++;
      if (tag_out !== exps[i]) begin
        n_err++; $display("FAIL search_%0d: got %h want %h", i, tag_out, exps[i]);
      end
    end
  endtask

  task automatic test_tag_write();
    operation_mode = 3'd2; cmp_addr = 10'h020; cmp_data = 2'b00; acc_en = 1'b0; tick();
    n_cmp++;
    if (tag_out !== 16'h5555) begin
      n_err++; $display("FAIL tw_setup: got %h want 5555", tag_out);
    end
    operation_mode = 3'd4; ppg_addr = 4'h3; ppg_data = 2'b11; update_signal = 1'b1; tick();
    update_signal = 1'b0;
    n_cmp++;
    if (dut_row(35) !== 32'h33333333) begin
      n_err++; $display("FAIL tw_row35: got %h want 33333333", dut_row(35));
    end
    operation_mode = 3'd3; ppg_data = 2'b11; acc_en = 1'b0; tick();
    n_cmp++;
    if (tag_out !== 16'h5555) begin
      n_err++; $display("FAIL ppg_search: got %h want 5555", tag_out);
    end
  endtask

  task automatic test_read();
    operation_mode = 3'd5; cmp_addr = 10'd1; addr_select = 1'b1; tick();
    n_cmp++;
    if (tag_out !== 16'hFFFF) begin
      n_err++; $display("FAIL read_odd: got %h want ffff", tag_out);
    end
    addr_select = 1'b0; tick();
    n_cmp++;
    if (tag_out !== 16'h0000) begin
      n_err++; $display("FAIL read_even: got %h want 0000", tag_out);
    end
  endtask

  task automatic test_hold_and_done();
    operation_mode = 3'd5; cmp_addr = 10'd1; addr_select = 1'b1; tick();
    chip_enable = 1'b0; operation_mode = 3'd6; tick();
    n_cmp++;
    if (tag_out !== 16'hFFFF) begin
      n_err++; $display("FAIL hold_tag: got %h want ffff", tag_out);
    end
    operation_mode = 3'd0; cmp_addr = {5'd2, 5'd0}; data_in = 16'hFFFF; tick();
    n_cmp++;
    if (dut_row(2) !== 32'h00000000) begin
      n_err++; $display("FAIL hold_row2: got %h want 00000000", dut_row(2));
    end
    chip_enable = 1'b1; write_done = 1'b1; tick();
    write_done = 1'b0;
    n_cmp++;
    if (tag_out !== 16'h0000) begin
      n_err++; $display("FAIL wdone_tag: got %h want 0000", tag_out);
    end
    n_cmp++;
    if (dut_row(2) !== 32'h00000000) begin
      n_err++; $display("FAIL wdone_row2: got %h want 00000000", dut_row(2));
    end
  endtask

  task automatic test_reset_mid();
    operation_mode = 3'd2; cmp_addr = 10'h020; cmp_data = 2'b00; acc_en = 1'b1; tick();
    #3; rst = 1'b0; #1;
    m_tag = 16'h0000;
    n_cmp++;
    if (tag_out !== 16'h0000) begin
      n_err++; $display("FAIL rst_async: got %h want 0000", tag_out);
    end
    operation_mode = 3'd0; cmp_addr = {5'd2, 5'd0}; addr_select = 1'b1; data_in = 16'hFFFF;
    @(posedge CLK); #1;
    n_cmp++;
    if (dut_row(2) !== ref_mem[2]) begin
      n_err++; $display("FAIL rst_nowrite: got %h want %h", dut_row(2), ref_mem[2]);
    end
    #2; rst = 1'b1;
    operation_mode = 3'd7;
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back_random();
    int rr;
    for (int i = 0; i < 500; i++) begin
      chip_enable    = ($urandom_range(0, 9) != 0);
      write_done     = ($urandom_range(0, 15) == 0);
      operation_mode = 3'($urandom_range(0, 7));
      addr_select    = 1'($urandom);
      cmp_addr       = 10'($urandom);
      ppg_addr       = 4'($urandom);
      data_in        = 16'($urandom);
      update_signal  = ($urandom_range(0, 3) != 0);
      tag_in         = 16'($urandom);
      cmp_data       = 2'($urandom);
      ppg_data       = 2'($urandom);
      acc_en         = 1'($urandom);
      tick();
      n_cmp++;
      if (tag_out !== m_tag) begin
        n_err++; $display("FAIL rand_tag_%0d: got %h want %h", i, tag_out, m_tag);
      end
      rr = $urandom_range(0, 39);
      n_cmp++;
      if (dut_row(rr) !== ref_mem[rr]) begin
        n_err++; $display("FAIL rand_row%0d_%0d: got %h want %h", rr, i, dut_row(rr), ref_mem[rr]);
      end
    end
    for (int r = 0; r < 40; r++) begin
      n_cmp++;
      if (dut_row(r) !== ref_mem[r]) begin
        n_err++; $display("FAIL final_row%0d: got %h want %h", r, dut_row(r), ref_mem[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    init_array();
    test_direct_write();
    test_masked_write();
    test_search_acc();
    test_tag_write();
    test_read();
    test_hold_and_done();
    test_reset_mid();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
